// File: rtl/com_cmd_pack.sv
// com_cmd_pack -- command-frame encoder (transmit side of the com command path).
// On an fs request it captures a command, writes an 11-byte frame (password
// header, command fields, modulo-256 checksum) into the command RAM one byte
// per cycle, then runs the fs_eth/fd_eth handshake with the eth transmitter.
// Ports:
//   clk, rst           clock (rising edge), async active-low reset
//   fs / fd            level request / done handshake with the requester
//   password, btype,
//   com_cmd, trgg_cmd  command fields, captured once per request
//   txen, txa, txd     RAM byte write port (registered)
//   fs_eth / fd_eth    transmit request / done handshake with eth
//   tx_addr, tx_len    frame location for eth (constants)
module com_cmd_pack #(
  parameter logic [7:0]  RAM_ADDR_INIT = 8'h0A,
  parameter logic [12:0] FRAME_LEN     = 13'd11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic [15:0] password,
  input  logic [3:0]  btype,
  input  logic [11:0] com_cmd,
  input  logic [39:0] trgg_cmd,
  output logic        txen,
  output logic [7:0]  txa,
  output logic [7:0]  txd,
  output logic        fs_eth,
  input  logic        fd_eth,
  output logic [7:0]  tx_addr,
  output logic [12:0] tx_len
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_WRITE, S_CSUM, S_ETH, S_DONE
  } state_t;

  typedef struct packed {
    logic [15:0] password;
    logic [3:0]  btype;
    logic [11:0] com_cmd;
    logic [39:0] trgg_cmd;
  } cmd_t;

  state_t     state, state_nxt;
  cmd_t       cmd;
  logic [3:0] idx;
  logic [7:0] csum;
  logic [7:0] byte_val;

  assign tx_addr = RAM_ADDR_INIT;
  assign tx_len  = FRAME_LEN;

  // Frame byte selected by the running index (bytes 0..9; checksum is separate).
  always_comb begin
    byte_val = 8'h00;
    case (idx)
      4'd0: byte_val = cmd.password[15:8];
      4'd1: byte_val = cmd.password[7:0];
      4'd2: byte_val = {4'h0, cmd.btype};
      4'd3: byte_val = {4'h0, cmd.com_cmd[11:8]};
      4'd4: byte_val = cmd.com_cmd[7:0];
      4'd5: byte_val = cmd.trgg_cmd[39:32];
      4'd6: byte_val = cmd.trgg_cmd[31:24];
      4'd7: byte_val = cmd.trgg_cmd[23:16];
      4'd8: byte_val = cmd.trgg_cmd[15:8];
      4'd9: byte_val = cmd.trgg_cmd[7:0];
      default: byte_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // A stale fd_eth from a previous transfer must clear before a new frame.
      S_IDLE:  if (fs && !fd_eth) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_WRITE;
      S_WRITE: if (idx == 4'd9) state_nxt = S_CSUM;
      S_CSUM:  state_nxt = S_ETH;
      // fd_eth only counts once our request is actually on the wire.
      S_ETH:   if (fs_eth && fd_eth) state_nxt = S_DONE;
      S_DONE:  if (!fs && !fd_eth) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd    <= '0;
      idx    <= 4'd0;
      csum   <= 8'h00;
      txen   <= 1'b0;
      txa    <= RAM_ADDR_INIT;
      txd    <= 8'h00;
      fs_eth <= 1'b0;
      fd     <= 1'b0;
    end else begin
      txen <= 1'b0;
      case (state)
        S_LATCH: begin
          cmd  <= '{password: password, btype: btype, com_cmd: com_cmd, trgg_cmd: trgg_cmd};
          idx  <= 4'd0;
          csum <= 8'h00;
        end
        S_WRITE: begin
          txen <= 1'b1;
          txa  <= RAM_ADDR_INIT + {4'h0, idx};  // 8-bit add wraps past 8'hFF
          txd  <= byte_val;
          csum <= csum + byte_val;
          idx  <= idx + 4'd1;
        end
        S_CSUM: begin
          txen <= 1'b1;
          txa  <= RAM_ADDR_INIT + 8'd10;
          txd  <= csum;
        end
        S_ETH: begin
          if (fs_eth && fd_eth) begin
            fs_eth <= 1'b0;
            fd     <= 1'b1;
          end else begin
            fs_eth <= 1'b1;
          end
        end
        S_DONE: if (!fs && !fd_eth) fd <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_com_cmd_pack.sv
module tb_com_cmd_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs;
  logic [15:0] password;
  logic [3:0]  btype;
  logic [11:0] com_cmd;
  logic [39:0] trgg_cmd;
  logic        fd_eth;
  logic        fd, txen, fs_eth;
  logic [7:0]  txa, txd, tx_addr;
  logic [12:0] tx_len;
  logic        fd_w, txen_w, fs_eth_w;
  logic [7:0]  txa_w, txd_w, tx_addr_w;
  logic [12:0] tx_len_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  com_cmd_pack dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd), .password(password), .btype(btype),
    .com_cmd(com_cmd), .trgg_cmd(trgg_cmd), .txen(txen), .txa(txa), .txd(txd),
    .fs_eth(fs_eth), .fd_eth(fd_eth), .tx_addr(tx_addr), .tx_len(tx_len)
  );

  // Second instance placed near the top of the address space to exercise wrap.
  com_cmd_pack #(.RAM_ADDR_INIT(8'hFA)) dut_w (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd_w), .password(password), .btype(btype),
    .com_cmd(com_cmd), .trgg_cmd(trgg_cmd), .txen(txen_w), .txa(txa_w), .txd(txd_w),
    .fs_eth(fs_eth_w), .fd_eth(fd_eth), .tx_addr(tx_addr_w), .tx_len(tx_len_w)
  );

  // RAM models and event counters.
  logic [7:0] ram   [256];
  logic [7:0] ram_w [256];
  int txen_cnt = 0;
  int eth_rises = 0;
  logic eth_prev = 1'b0;

  always @(posedge clk) begin
    if (txen)   ram[txa]     <= txd;
    if (txen_w) ram_w[txa_w] <= txd_w;
    if (txen) txen_cnt <= txen_cnt + 1;
    if (fs_eth && !eth_prev) eth_rises <= eth_rises + 1;
    eth_prev <= fs_eth;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare both RAM images against a frame packed byte 0 in the MSBs.
  task automatic check_frame(input string tag, input logic [87:0] f);
    logic [7:0] a, aw;
    for (int k = 0; k < 11; k++) begin
      a  = 8'h0A + 8'(k);
      aw = 8'hFA + 8'(k);
      check($sformatf("%s_b%0d", tag, k), {56'h0, ram[a]}, {56'h0, f[87-8*k -: 8]});
      check($sformatf("%s_wrap_b%0d", tag, k), {56'h0, ram_w[aw]}, {56'h0, f[87-8*k -: 8]});
    end
  endtask

  // Ticks until fs_eth is seen, bounded; returns the edge index (edge 0 = first).
  task automatic wait_eth(output int edge_idx);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!fs_eth && n < 200);
    edge_idx = n - 1;
  endtask

  task automatic set_cmd(input logic [15:0] p, input logic [3:0] b,
                         input logic [11:0] c, input logic [39:0] t);
    password = p; btype = b; com_cmd = c; trgg_cmd = t;
  endtask

  initial begin
    int e, base_tx, base_rise;
    rst = 1'b0; fs = 1'b0; fd_eth = 1'b0;
    set_cmd(16'h0, 4'h0, 12'h0, 40'h0);
    tick(); tick();

    // Reset state
    check("rst_fd", {63'h0, fd}, 64'h0);
    check("rst_fs_eth", {63'h0, fs_eth}, 64'h0);
    check("rst_txen", {63'h0, txen}, 64'h0);
    check("rst_txa", {56'h0, txa}, 64'h0A);
    check("rst_txd", {56'h0, txd}, 64'h0);
    check("rst_txa_w", {56'h0, txa_w}, 64'hFA);
    check("tx_addr", {56'h0, tx_addr}, 64'h0A);
    check("tx_len", {51'h0, tx_len}, 64'd11);
    rst = 1'b1;
    tick();

    // Test 1 + 3: basic frame, wrap instance, latency
    set_cmd(16'h55AA, 4'h3, 12'hABC, 40'h0102030405);
    base_tx = txen_cnt; base_rise = eth_rises;
    fs = 1'b1;
    wait_eth(e);
    check("t1_eth_edge", 64'(e), 64'd13);
    check("t1_fs_eth", {63'h0, fs_eth}, 64'h1);
    tick();
    check("t1_txen_cycles", 64'(txen_cnt - base_tx), 64'd11);
    check_frame("t1", 88'h55AA030ABC0102030405D7);
    check("t3_wrap_csum_at_04", {56'h0, ram_w[8'h04]}, 64'hD7);

    // Test 2: eth handshake
    repeat (50) tick();
    check("t2_fs_eth_held", {63'h0, fs_eth}, 64'h1);
    check("t2_fd_low", {63'h0, fd}, 64'h0);
    fd_eth = 1'b1;
    tick();
    check("t2_fs_eth_drop", {63'h0, fs_eth}, 64'h0);
    check("t2_fd_high", {63'h0, fd}, 64'h1);
    fd_eth = 1'b0;
    tick();
    check("t2_fd_hold", {63'h0, fd}, 64'h1);
    fs = 1'b0;
    tick();
    check("t2_fd_clear", {63'h0, fd}, 64'h0);
    check("t2_one_eth", 64'(eth_rises - base_rise), 64'd1);
    tick();

    // Test 4: input changes and fs re-pulse during WRITE are ignored
    set_cmd(16'h1234, 4'h5, 12'h678, 40'h9ABCDEF011);
    base_tx = txen_cnt; base_rise = eth_rises;
    fs = 1'b1;
    tick(); tick(); tick();
    set_cmd(16'hFFFF, 4'hF, 12'hFFF, 40'hFF_FFFF_FFFF);
    fs = 1'b0;
    tick();
    fs = 1'b1;
    wait_eth(e);
    check("t4_fs_eth", {63'h0, fs_eth}, 64'h1);
    fd_eth = 1'b1;
    tick();
    fd_eth = 1'b0;
    check("t4_fd_high", {63'h0, fd}, 64'h1);
    fs = 1'b0;
    tick(); tick();
    check("t4_fd_clear", {63'h0, fd}, 64'h0);
    repeat (30) tick();
    check("t4_one_eth", 64'(eth_rises - base_rise), 64'd1);
    check("t4_txen_cycles", 64'(txen_cnt - base_tx), 64'd11);
    check_frame("t4", 88'h1234050678_9ABCDEF011_FE);

    // Test 5: async reset during WRITE idx 4
    set_cmd(16'hDEAD, 4'h7, 12'h111, 40'h2233445566);
    fs = 1'b1;
    repeat (6) tick();
    check("t5_txen_before", {63'h0, txen}, 64'h1);
    #2 rst = 1'b0;
    #1;
    check("t5_txen_async", {63'h0, txen}, 64'h0);
    check("t5_fd_async", {63'h0, fd}, 64'h0);
    check("t5_fs_eth_async", {63'h0, fs_eth}, 64'h0);
    check("t5_txa_async", {56'h0, txa}, 64'h0A);
    fs = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // Test 6: stale fd_eth blocks start, then all-ones frame
    set_cmd(16'hFFFF, 4'hF, 12'hFFF, 40'hFF_FFFF_FFFF);
    fd_eth = 1'b1;
    fs = 1'b1;
    base_tx = txen_cnt; base_rise = eth_rises;
    repeat (20) tick();
    check("t6_blocked_txen", 64'(txen_cnt - base_tx), 64'd0);
    check("t6_blocked_fs_eth", {63'h0, fs_eth}, 64'h0);
    fd_eth = 1'b0;
    wait_eth(e);
    check("t6_eth_edge", 64'(e), 64'd13);
    tick();
    check("t6_txen_cycles", 64'(txen_cnt - base_tx), 64'd11);
    check_frame("t6", 88'hFFFF0F0FFFFFFFFFFFFF16);
    fd_eth = 1'b1;
    tick();
    fd_eth = 1'b0;
    check("t6_fd_high", {63'h0, fd}, 64'h1);
    fs = 1'b0;
    tick(); tick();
    check("t6_fd_clear", {63'h0, fd}, 64'h0);
    check("t6_one_eth", 64'(eth_rises - base_rise), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
